seq_mult_param: RTL and testbench
=================================

// Module: seq_mult_param
// PURPOSE
// - Parametrised sequential shift-add multiplier: one adder/subtractor, one partial product per clock.
// - Multiplies two W-bit operands into a 2W-bit product in W cycles, selectable signed/unsigned per operation.
// - Start/busy/done handshake; sits in the datapath wherever area matters more than throughput.
// - Successor of the fixed 8-bit, unsigned-only sequential multiplier.
// PARAMETERS
// - W           8    operand width, W >= 2; product width is 2*W
// - CNT_W       $clog2(W)  step-counter width (derived, not overridden)
// PORTS
// - clk        in   1     single clock, all logic on posedge
// - rst        in   1     synchronous reset, active-high
// - start      in   1     request; accepted only when busy==0
// - is_signed  in   1     1: two's-complement operands; 0: unsigned; sampled with start
// - a          in   W     multiplicand; sampled on accept edge
// - b          in   W     multiplier; sampled on accept edge
// - busy       out  1     operation in progress; start ignored while high
// - done       out  1     one-cycle pulse; p valid in this cycle
// - p          out  2W    product; held until the next completion
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=IDLE, busy=0, done=0, p=0, counter=0; any operation in flight is discarded.
// - FSM states IDLE, RUN, FIN (typedef in package).
//   IDLE --start--> RUN; RUN --cnt==W-1--> FIN; FIN --start--> RUN, else FIN -> IDLE.
// - Accept: start=1 and busy=0 at posedge.
//   Latch a, b, is_signed; clear the accumulator; counter=0; busy=1 from the next cycle.
// - RUN, step i (i=0..W-1): pp = b_bit_i ? A : 0, where A is the latched a extended to W+1 bits.
//   The extension is the sign bit if signed, 0 if unsigned.
// - Step i: acc_hi(W+1) = acc_hi +/- pp.
//   It is a subtract only when signed and i==W-1 (negative weight of the multiplier MSB); every other step adds.
// - After each step: {acc_hi, acc_lo} shifts right 1.
//   Signed: arithmetic shift (shift in acc_hi MSB). Unsigned: the shifted-in bit is the adder carry.
// - After step W-1: p <= {acc_hi[W-1:0], acc_lo}, done=1, busy=0, state=FIN.
// - Latency: accept at edge k -> done=1 and p valid immediately after edge k+W (W cycles), exactly 1 cycle wide.
// - Throughput: back-to-back allowed.
//   start=1 in the done cycle is accepted; busy is high again the next cycle; one op per W+1 cycles max.
// - start=1 while busy=1: ignored entirely; latched operands are untouched, no queuing.
// - is_signed, a, b changes while busy: no effect.
// - p changes only on a completion edge or reset; done never asserts without a prior accept.
// - Width rule: the result is exact over the full range; no overflow is possible in 2W bits for either mode.
// - Counter is CNT_W bits and compares against W-1; it never wraps during RUN.
// STRUCTURE
// - Package mul_pkg: typedef enum logic [1:0] {IDLE, RUN, FIN} mul_state_t; function clog2-safe CNT_W helper.
// - Sub-module mul_addsub_step #(W): combinational (W+1)-bit add/sub of acc_hi and pp, with carry out.
//   Instantiated once; the FSM, counter and shift registers stay in the top.
// TESTING
// - W=8 unsigned, a=255, b=255, start one cycle
//   -> done exactly 8 cycles after the accept edge, p=16'hFE01, busy high for 8 cycles.
// - W=8 signed, a=-128, b=-128 -> p=16'h4000; then a=-1, b=127 -> p=16'hFF81; then a=127, b=-128 -> p=16'hC080.
// - Back-to-back: start held high, unsigned 3*5 then 7*9
//   -> done pulses 9 cycles apart, p=15 then p=63, no lost op.
// - start pulsed with a=1, b=1 at cycle 3 of a running 200*100
//   -> ignored, p=16'h4E20 (20000), single done pulse.
// - rst asserted at cycle 4 of an op -> next cycle busy=0, done=0, p=0; no done afterwards until a new start.
// - W=4 regression: unsigned 15*15 -> 8'hE1 after 4 cycles; signed -8*-8 -> 8'h40; signed -8*7 -> 8'hC8.

Source files
------------

// File: rtl/seq_mult_param_pkg.sv
// mul_pkg: shared FSM state type and counter-width helper for the sequential multiplier.
package mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} mul_state_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/seq_mult_param_if.sv
// seq_mult_param_if: start/busy/done handshake and operand/product bus.
interface seq_mult_param_if #(parameter int W = 8);
  logic           start;
  logic           is_signed;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;
  modport master(output start, is_signed, a, b, input busy, done, p);
  modport slave(input start, is_signed, a, b, output busy, done, p);
endinterface

// File: rtl/seq_mult_param_addsub.sv
// mul_addsub_step: (W+1)-bit add/subtract of accumulator and partial product with carry out.
module mul_addsub_step #(parameter int W = 8) (
  input  logic [W:0] x,
  input  logic [W:0] y,
  input  logic       sub,
  output logic [W:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, x} + {1'b0, sub ? ~y : y} + (W+2)'(sub);
endmodule

// File: rtl/seq_mult_param.sv
// seq_mult_param: W-cycle shift-add multiplier, signed or unsigned per operation.
module seq_mult_param import mul_pkg::*; #(parameter int W = 8) (
  input logic             clk,
  input logic             rst,
  seq_mult_param_if.slave bus
);
  localparam int CNT_W = cnt_w(W);
  mul_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]   a_q, acc_lo, nxt_lo;
  logic [W:0]     acc_hi, nxt_hi, pp, sum;
  logic           sgn, co, last, accept;
  assign last   = cnt == CNT_W'(W-1);
  assign accept = bus.start && !bus.busy;
  // acc_lo starts as the multiplier and is consumed from its LSB as product bits shift in
  assign pp     = acc_lo[0] ? {sgn & a_q[W-1], a_q} : '0;
  mul_addsub_step #(.W(W)) u_step (.x(acc_hi), .y(pp), .sub(sgn & last), .s(sum), .co(co));
  assign nxt_hi = {sgn ? sum[W] : co, sum[W:1]};
  assign nxt_lo = {sum[0], acc_lo[W-1:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      acc_lo   <= '0;
      acc_hi   <= '0;
      sgn      <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.p    <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state == RUN) begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        cnt    <= cnt + 1'b1;
        if (last) begin
          bus.p    <= {nxt_hi[W-1:0], nxt_lo};
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= FIN;
        end
      end else if (accept) begin
        a_q      <= bus.a;
        acc_lo   <= bus.b;
        sgn      <= bus.is_signed;
        acc_hi   <= '0;
        cnt      <= '0;
        bus.busy <= 1'b1;
        state    <= RUN;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed and random checks of the multiplier against an arithmetic model.
module tb_seq_mult_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, passed = 0, fails = 0;
  always #5 clk = ~clk;
  seq_mult_param_if #(.W(8)) b8();
  seq_mult_param_if #(.W(4)) b4();
  seq_mult_param #(.W(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  seq_mult_param #(.W(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input int w, input logic s, input logic [31:0] x, input logic [31:0] y);
    longint xi, yi;
    xi = (s && x[w-1]) ? longint'(x) - (longint'(1) << w) : longint'(x);
    yi = (s && y[w-1]) ? longint'(y) - (longint'(1) << w) : longint'(y);
    return 32'((xi * yi) & ((longint'(1) << (2*w)) - 1));
  endfunction

  task automatic run8(input string tag, input logic s, input logic [7:0] x, input logic [7:0] y);
    int n, bc;
    logic [31:0] e;
    e = model(8, s, {24'b0, x}, {24'b0, y});
    @(negedge clk); b8.start = 1; b8.is_signed = s; b8.a = x; b8.b = y;
    @(negedge clk); b8.start = 0; b8.a = 8'($urandom); b8.b = 8'($urandom); b8.is_signed = 1'($urandom);
    n = 0; bc = 0;
    while (!b8.done && n < 40) begin
      bc += int'(b8.busy);
      @(negedge clk); n++;
    end
    chk({tag, " latency"}, n, 8);
    chk({tag, " busy_cycles"}, bc, 8);
    chk({tag, " p"}, {16'b0, b8.p}, e);
    @(negedge clk);
    chk({tag, " done_width"}, {31'b0, b8.done}, 0);
  endtask

  task automatic run4(input string tag, input logic s, input logic [3:0] x, input logic [3:0] y);
    int n;
    @(negedge clk); b4.start = 1; b4.is_signed = s; b4.a = x; b4.b = y;
    @(negedge clk); b4.start = 0;
    n = 0;
    while (!b4.done && n < 40) begin
      @(negedge clk); n++;
    end
    chk({tag, " latency"}, n, 4);
    chk({tag, " p"}, {24'b0, b4.p}, model(4, s, {28'b0, x}, {28'b0, y}));
  endtask

  initial begin
    int n, dc;
    b8.start = 0; b8.is_signed = 0; b8.a = 0; b8.b = 0;
    b4.start = 0; b4.is_signed = 0; b4.a = 0; b4.b = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset busy", {31'b0, b8.busy}, 0);
    chk("reset done", {31'b0, b8.done}, 0);
    chk("reset p", {16'b0, b8.p}, 0);
    run8("u255x255", 0, 8'd255, 8'd255);
    chk("u255x255 const", {16'b0, b8.p}, 32'hFE01);
    run8("s-128x-128", 1, 8'h80, 8'h80);
    chk("s-128x-128 const", {16'b0, b8.p}, 32'h4000);
    run8("s-1x127", 1, 8'hFF, 8'h7F);
    chk("s-1x127 const", {16'b0, b8.p}, 32'hFF81);
    run8("s127x-128", 1, 8'h7F, 8'h80);
    chk("s127x-128 const", {16'b0, b8.p}, 32'hC080);
    // start held high across two operations
    @(negedge clk); b8.start = 1; b8.is_signed = 0; b8.a = 8'd3; b8.b = 8'd5;
    @(negedge clk); b8.a = 8'd7; b8.b = 8'd9;
    n = 0;
    while (!b8.done && n < 40) begin
      @(negedge clk); n++;
    end
    chk("b2b latency1", n, 8);
    chk("b2b p1", {16'b0, b8.p}, 15);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!b8.done && n < 40);
    b8.start = 0;
    chk("b2b gap", n, 9);
    chk("b2b p2", {16'b0, b8.p}, 63);
    @(negedge clk);
    chk("b2b idle", {31'b0, b8.busy}, 0);
    // start pulse during a running operation must be ignored
    @(negedge clk); b8.start = 1; b8.is_signed = 0; b8.a = 8'd200; b8.b = 8'd100;
    @(negedge clk); b8.start = 0;
    n = 0;
    while (!b8.done && n < 40) begin
      b8.start = (n == 3); b8.a = 8'd1; b8.b = 8'd1;
      @(negedge clk); n++;
    end
    b8.start = 0;
    chk("ign latency", n, 8);
    chk("ign p", {16'b0, b8.p}, 20000);
    dc = 0;
    repeat (15) begin
      @(negedge clk); dc += int'(b8.done);
    end
    chk("ign extra_done", dc, 0);
    // reset in the middle of an operation
    @(negedge clk); b8.start = 1; b8.is_signed = 0; b8.a = 8'd200; b8.b = 8'd100;
    @(negedge clk); b8.start = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("rst busy", {31'b0, b8.busy}, 0);
    chk("rst done", {31'b0, b8.done}, 0);
    chk("rst p", {16'b0, b8.p}, 0);
    dc = 0;
    repeat (15) begin
      @(negedge clk); dc += int'(b8.done);
    end
    chk("rst no_done", dc, 0);
    for (int i = 0; i < 24; i++) run8("rnd", 1'($urandom), 8'($urandom), 8'($urandom));
    run4("w4 u15x15", 0, 4'hF, 4'hF);
    chk("w4 u15x15 const", {24'b0, b4.p}, 32'hE1);
    run4("w4 s-8x-8", 1, 4'h8, 4'h8);
    chk("w4 s-8x-8 const", {24'b0, b4.p}, 32'h40);
    run4("w4 s-8x7", 1, 4'h8, 4'h7);
    chk("w4 s-8x7 const", {24'b0, b4.p}, 32'hC8);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
